// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the execute stage and a byte-addressed,
// big-endian, word-wide data memory. Byte/halfword/word loads are extracted
// and sign/zero-extended; sub-word stores are read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// requests are rejected with resp_misaligned; when undefined, the low
// address bits are cleared and the access proceeds.
module lsu_ctrl #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_range_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writeData,
  output logic              mem_memoryWrite,
  output logic              mem_memoryRead,
  input  logic [31:0]       mem_readData
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DATA,
    RMW_RD,
    RMW_MERGE,
    WR
  } state_t;

  state_t            state_q;
  logic [1:0]        req_size_q;
  logic              req_unsigned_q;
  logic [1:0]        req_off_q;
  logic [31:0]       req_wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_mis_q;
  logic              resp_rng_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_rd_q;
  logic              mem_wr_q;

  logic [ADDR_W-1:0] eff_addr_d;
  logic [ADDR_W-1:0] base_d;
  logic              misaligned_d;
  logic              range_err_d;
  logic [31:0]       load_data_d;
  logic [31:0]       merge_data_d;

  // Select the addressed big-endian lane of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    unique case (size)
      2'b00:   r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of an existing word with the store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    unique case (size)
      2'b00: begin
        unique case (off)
          2'd0:    r[31:24] = wdata[7:0];
          2'd1:    r[23:16] = wdata[7:0];
          2'd2:    r[15:8]  = wdata[7:0];
          default: r[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0]  = wdata[15:0];
        else        r[31:16] = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Decode the incoming request: effective address, alignment and range.
  always_comb begin
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    eff_addr_d   = req_addr;
    misaligned_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned_d = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    if (req_size == 2'b01)  eff_addr_d[0]   = 1'b0;
    else if (req_size[1])   eff_addr_d[1:0] = 2'b00;
`endif
    base_d      = {eff_addr_d[ADDR_W-1:2], 2'b00};
    range_err_d = (base_d >= ADDR_W'(MEM_BYTES));
  end

  assign load_data_d  = lane_extract(mem_readData, req_size_q, req_off_q, req_unsigned_q);
  assign merge_data_d = lane_merge(mem_readData, req_size_q, req_off_q, req_wdata_q);

  // Sequence the memory port and register every response/strobe output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      req_size_q     <= 2'b00;
      req_unsigned_q <= 1'b0;
      req_off_q      <= 2'b00;
      req_wdata_q    <= 32'h0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0;
      resp_mis_q     <= 1'b0;
      resp_rng_q     <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'h0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      resp_valid_q <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_rng_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_size_q     <= req_size;
            req_unsigned_q <= req_unsigned;
            req_off_q      <= eff_addr_d[1:0];
            req_wdata_q    <= req_wdata;
            mem_addr_q     <= base_d;
            if (misaligned_d || range_err_d) begin
              resp_valid_q <= 1'b1;
              resp_mis_q   <= misaligned_d;
              resp_rng_q   <= range_err_d;
              resp_rdata_q <= 32'h0;
            end else if (!req_write) begin
              mem_rd_q <= 1'b1;
              state_q  <= RD;
            end else if (req_size[1]) begin
              mem_wr_q    <= 1'b1;
              mem_wdata_q <= req_wdata;
              state_q     <= WR;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= RMW_RD;
            end
          end
        end
        RD: begin
          mem_rd_q <= 1'b0;
          state_q  <= RD_DATA;
        end
        RD_DATA: begin
          resp_rdata_q <= load_data_d;
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        RMW_RD: begin
          mem_rd_q <= 1'b0;
          state_q  <= RMW_MERGE;
        end
        RMW_MERGE: begin
          mem_wdata_q <= merge_data_d;
          mem_wr_q    <= 1'b1;
          state_q     <= WR;
        end
        WR: begin
          mem_wr_q     <= 1'b0;
          resp_rdata_q <= 32'h0;
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_range_err  = resp_rng_q;
  assign mem_address     = mem_addr_q;
  assign mem_writeData   = mem_wdata_q;
  assign mem_memoryWrite = mem_wr_q;
  assign mem_memoryRead  = mem_rd_q;

endmodule
